stream_demux_1xn: RTL

Registered 1-to-NUM_OUT packet demultiplexer with valid/ready handshaking, generalising the single-bit 1x2 demultiplexer to parametrised data width and output count. The first beat of each packet selects a destination, which stays locked until the beat marked `in_last`. Packets whose select is out of range are consumed and counted rather than routed. The block sits between a single upstream stream source and NUM_OUT downstream consumers.

---
 rtl/stream_demux_1xn.sv | 139 +++++++++++++
 1 files changed

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-NUM_OUT packet demultiplexer with valid/ready handshaking.
// The first beat selects a channel that stays locked until the last beat.
module stream_demux_1xn #(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4,
    parameter int CNT_W   = 8,
    localparam int SEL_W  = $clog2(NUM_OUT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    input  logic [SEL_W-1:0]   in_sel,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
    output logic [CNT_W-1:0]   drop_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        DROP
    } state_t;

    localparam logic [SEL_W:0] NUM_OUT_L = (SEL_W+1)'(NUM_OUT);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] lock_ch;
    logic [SEL_W-1:0] lock_nxt;
    logic [SEL_W-1:0] load_ch;
    logic [SEL_W-1:0] buf_ch;
    logic             buf_full;
    logic             sel_ok;
    logic             accept;
    logic             deliver;
    logic             load;
    logic             drop_inc;

    always_comb begin
        out_valid = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            out_valid[k] = buf_full && (buf_ch == SEL_W'(k));
        end
    end

    assign sel_ok  = ({1'b0, in_sel} < NUM_OUT_L);
    // Selected consumer's ready; non-selected ready bits are masked out.
    assign deliver = |(out_valid & out_ready);
    assign accept  = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_ch;
        load_ch   = lock_ch;
        load      = 1'b0;
        drop_inc  = 1'b0;
        in_ready  = !buf_full || deliver;
        unique case (state)
            IDLE: begin
                if (!sel_ok) begin
                    in_ready = 1'b1;
                end
                if (accept) begin
                    if (sel_ok) begin
                        load     = 1'b1;
                        load_ch  = in_sel;
                        lock_nxt = in_sel;
                        if (!in_last) begin
                            state_nxt = ROUTE;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        if (!in_last) begin
                            state_nxt = DROP;
                        end
                    end
                end
            end
            ROUTE: begin
                if (accept) begin
                    load = 1'b1;
                    if (in_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                in_ready = 1'b1;
                if (accept && in_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lock_ch <= '0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_nxt;
        end
    end

    // Reload on accept wins over delivery, keeping one beat per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
            buf_ch   <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (load) begin
            buf_full <= 1'b1;
            buf_ch   <= load_ch;
            out_data <= in_data;
            out_last <= in_last;
        end else if (deliver) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_inc && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
